sram22_req_ctrl: RTL and testbench

// - Initiator-side controller for single-port sram22 macros (clk/we/wmask/addr/din/dout, 1-cycle read latency).
// - Converts a valid/ready request channel into macro cycles; returns read data on a valid/ready response channel.
// - Holds a 2-entry response FIFO so response backpressure never drops macro dout; optional post-reset zero sweep.

---
 rtl/sram22_req_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sram22_req_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram22_req_ctrl
//
// Initiator-side controller for a single-port sram22 macro (1-cycle read
// latency). A valid/ready request channel is turned into macro cycles, and read
// data returns on a valid/ready response channel. A 2-entry response FIFO
// ensures that macro dout is never lost when the response channel stalls.
//
// Build option:
//   SRAM22_CTRL_INIT_EN  when defined, the INIT state writes zero to every
//                        macro address (one per cycle) before entering RUN.
//                        When undefined, INIT lasts a single cycle and the
//                        macro is not written.
//
// Ports:
//   clk, rst_n                 clock (posedge) / asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we                     1 = write, 0 = read
//   req_wmask                  per-lane write mask (lane = DATA_WIDTH/WMASK_WIDTH bits)
//   req_addr, req_wdata        word address and write data
//   rsp_valid/rsp_ready        response handshake (reads only)
//   rsp_rdata                  read data, driven by the FIFO head
//   init_done                  high once the controller is in RUN
//   sram_we/wmask/addr/din     to the macro
//   sram_dout                  from the macro, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram22_req_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WMASK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  // response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  // status
  output logic                   init_done,
  // macro interface
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Response path state
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  inflight;   // a read was issued to the macro last cycle

  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;
  logic                  read_credit;
  logic                  req_fire;

`ifdef SRAM22_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] sweep_addr;
`endif

  // ---------------------------------------------------------------------------
  // FSM: INIT -> RUN, RUN holds until reset
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable gets a default before any branch; otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: begin
`ifdef SRAM22_CTRL_INIT_EN
        // The counter wraps on the same edge that enters RUN.
        if (sweep_addr == {ADDR_WIDTH{1'b1}}) begin
          state_next = ST_RUN;
        end
`else
        state_next = ST_RUN;
`endif
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
    endcase
  end

`ifdef SRAM22_CTRL_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_addr <= '0;
    end else if (state == ST_INIT) begin
      sweep_addr <= sweep_addr + 1'b1;
    end
  end
`endif

  assign init_done = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Request acceptance
  // ---------------------------------------------------------------------------
  // A read needs a FIFO slot reserved for its data. Outstanding reads are those
  // buffered plus the one in flight; an entry leaving this cycle frees its slot
  // immediately, which is what lets a read issue every cycle while rsp_ready is
  // held high. The cost is a combinational path from rsp_ready to req_ready.
  assign rsp_valid   = (count != 2'd0);
  assign pop         = rsp_valid && rsp_ready;
  assign push        = inflight;
  assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign read_credit = (occupancy < 3'd2);

  assign req_ready = (state == ST_RUN) && (req_we || read_credit);
  assign req_fire  = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Macro drive: idle cycles are reads with no mask, which leave the array
  // untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
`ifdef SRAM22_CTRL_INIT_EN
    // rst_n gates the sweep so the macro sees an idle cycle while reset is
    // held, even though the FSM already sits in INIT.
    if ((state == ST_INIT) && rst_n) begin
      sram_we    = 1'b1;
      sram_wmask = {WMASK_WIDTH{1'b1}};
      sram_addr  = sweep_addr;
      sram_din   = '0;
    end else
`endif
    if (req_fire) begin
      sram_we    = req_we;
      sram_wmask = req_wmask;
      sram_addr  = req_addr;
      sram_din   = req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO. dout is only meaningful the cycle after a read, so it is
  // captured exactly when the in-flight flag is set; dout following a write is
  // never looked at. The credit check guarantees a push never meets a full FIFO.
  // ---------------------------------------------------------------------------
  // NOTE: the two data entries are reset along with the pointers so rsp_rdata
  // reads zero out of reset; at two words this is cheap, unlike a real RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      inflight    <= 1'b0;
    end else begin
      inflight <= req_fire && !req_we;
      if (push) begin
        fifo_mem[wr_ptr] <= sram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_rdata = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram22_req_ctrl
//
// Bench for sram22_req_ctrl with a behavioural sram22 macro model. The
// reference keeps a word-level image of the memory and a queue of expected
// responses, each tagged with the earliest cycle it may appear; at most two
// reads may be outstanding at once. Honours SRAM22_CTRL_INIT_EN.
// -----------------------------------------------------------------------------
module tb_sram22_req_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int MW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LANE  = DW / MW;

`ifdef SRAM22_CTRL_INIT_EN
  localparam int INIT_CYCLES = DEPTH;
  localparam bit INIT_CLEARS = 1'b1;
`else
  localparam int INIT_CYCLES = 1;
  localparam bit INIT_CLEARS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram22_req_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WMASK_WIDTH(MW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wmask (req_wmask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .sram_we   (sram_we),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- macro model: 1-cycle read, dout X after a write ----------
  logic [DW-1:0] smem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      smem[i] = INIT_CLEARS ? DW'($urandom) : '0;
    end
  end

  always @(posedge clk) begin
    if (sram_we) begin
      for (int l = 0; l < MW; l++) begin
        if (sram_wmask[l]) smem[sram_addr][l*LANE +: LANE] <= sram_din[l*LANE +: LANE];
      end
      sram_dout <= 'x;
    end else begin
      sram_dout <= smem[sram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          exp_q [$];
  logic [DW-1:0] got_data [$];
  int            got_cyc [$];
  logic [DW-1:0] want [$];
  int            cyc;
  int            checks;
  int            failures;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                          logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < MW; l++) begin
      if (m[l]) r[l*LANE +: LANE] = d[l*LANE +: LANE];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input int addr,
                       input logic [MW-1:0] m, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wmask = m;
    req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, '0, '0);
  endtask

  // One RUN cycle: inputs are already applied; check at the falling edge,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic run_cycle(output bit obs_ready);
    bit exp_valid;
    bit exp_ready;
    bit pop;
    bit fire;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    pop       = exp_valid && rsp_ready;
    exp_ready = req_we || ((exp_q.size() - (pop ? 1 : 0)) < 2);
    fire      = req_valid && exp_ready;
    obs_ready = req_ready;
    check("init_done", init_done, 1);
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) check("rsp_rdata", rsp_rdata, exp_q[0].data);
    check("sram_we", sram_we, fire && req_we);
    if (fire) begin
      check("sram_addr", sram_addr, req_addr);
      if (req_we) begin
        check("sram_din", sram_din, req_wdata);
        check("sram_wmask", sram_wmask, req_wmask);
      end
    end else begin
      check("sram_wmask_idle", sram_wmask, 0);
    end
    if (pop) begin
      got_data.push_back(rsp_rdata);
      got_cyc.push_back(cyc);
      void'(exp_q.pop_front());
    end
    if (fire) begin
      if (req_we) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
      else        exp_q.push_back('{data: ref_mem[req_addr], due: cyc + 2});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycles(input int n);
    bit r;
    for (int i = 0; i < n; i++) run_cycle(r);
  endtask

  task automatic expect_seq(input string tag);
    check({tag, "_count"}, got_data.size(), want.size());
    for (int i = 0; i < want.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), got_data[i], want[i]);
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cyc.delete();
    want.delete();
  endtask

  // Hold reset, check reset values, release, follow INIT into RUN.
  task automatic reset_and_init();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_wmask", sram_wmask, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_din", sram_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      #1;
      check("init_busy", init_done, 0);
      check("init_ready", req_ready, 0);
      check("init_we", sram_we, INIT_CLEARS);
      if (INIT_CLEARS) begin
        check("init_addr", sram_addr, i);
        check("init_din", sram_din, 0);
        check("init_wmask", sram_wmask, {MW{1'b1}});
      end
      @(negedge clk);
    end
    check("init_done_rise", init_done, 1);
    @(posedge clk);
    #1;
    exp_q.delete();
    if (INIT_CLEARS) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
  endtask

  initial begin
    bit r;
    int acc;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = smem[i];
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = smem[i];

    reset_and_init();

    // Read of a freshly initialised word
    clear_log();
    rsp_ready = 1'b1;
    drive(1, 0, 5, '0, '0);  run_cycle(r);
    idle();                  cycles(3);
    if (INIT_CLEARS) begin
      want.push_back(32'h0000_0000);
      expect_seq("init_rd5");
    end

    // Write then back-to-back read of the same word; 2-cycle latency
    clear_log();
    drive(1, 1, 3, 8'hFF, 32'hDEAD_BEEF); run_cycle(r);
    acc = cyc;
    drive(1, 0, 3, '0, '0);               run_cycle(r);
    idle();                               cycles(3);
    want.push_back(32'hDEAD_BEEF);
    expect_seq("raw");
    if (got_cyc.size() > 0) check("raw_latency", got_cyc[0], acc + 2);

    // Partial write: only the low four nibble lanes change
    clear_log();
    drive(1, 1, 3, 8'h0F, 32'h1234_5678); run_cycle(r);
    drive(1, 0, 3, '0, '0);               run_cycle(r);
    idle();                               cycles(3);
    want.push_back(32'hDEAD_5678);
    expect_seq("mask");

    // Backpressure: two reads fit, third waits, writes still pass
    drive(1, 1, 1, 8'hFF, 32'hA1A1_A1A1); run_cycle(r);
    drive(1, 1, 2, 8'hFF, 32'hB2B2_B2B2); run_cycle(r);
    drive(1, 1, 3, 8'hFF, 32'hC3C3_C3C3); run_cycle(r);
    clear_log();
    rsp_ready = 1'b0;
    drive(1, 0, 1, '0, '0);               run_cycle(r); check("bp_rd1_acc", r, 1);
    drive(1, 0, 2, '0, '0);               run_cycle(r); check("bp_rd2_acc", r, 1);
    drive(1, 0, 3, '0, '0);               run_cycle(r); check("bp_rd3_block", r, 0);
    drive(1, 1, 10, 8'hFF, 32'h5A5A_5A5A); run_cycle(r); check("bp_wr_acc", r, 1);
    check("bp_full_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    drive(1, 0, 3, '0, '0);               run_cycle(r); check("bp_rd3_acc", r, 1);
    idle();                               cycles(4);
    want.push_back(32'hA1A1_A1A1);
    want.push_back(32'hB2B2_B2B2);
    want.push_back(32'hC3C3_C3C3);
    expect_seq("bp");

    // Streaming reads 0..7 with no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i, 8'hFF, 32'h5000_0000 | DW'(i * 32'h0101)); run_cycle(r);
    end
    clear_log();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, i, '0, '0); run_cycle(r);
      check($sformatf("stream_acc_%0d", i), r, 1);
    end
    idle(); cycles(4);
    for (int i = 0; i < 8; i++) want.push_back(32'h5000_0000 | DW'(i * 32'h0101));
    expect_seq("stream");
    if (got_cyc.size() == 8) check("stream_span", got_cyc[7] - got_cyc[0], 7);

    // Randomised traffic against the reference
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15), MW'($urandom), DW'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      run_cycle(r);
    end
    idle();
    rsp_ready = 1'b1;
    cycles(4);
    check("rand_drained", exp_q.size(), 0);

    // Reset with one response buffered and one read in flight
    clear_log();
    rsp_ready = 1'b0;
    drive(1, 0, 1, '0, '0); run_cycle(r);
    drive(1, 0, 2, '0, '0); run_cycle(r);
    idle();
    check("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_done", init_done, 0);
    reset_and_init();
    clear_log();
    rsp_ready = 1'b1;
    cycles(5);
    check("post_rst_no_rsp", got_data.size(), 0);
    drive(1, 0, 1, '0, '0); run_cycle(r);
    idle();                 cycles(3);
    check("post_rst_rd_count", got_data.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
